// File: rtl/event_encoder_if.sv
// Event-encoder bus: event lines and acknowledge in, select code and status out.
// Handshake: s is valid while valid=1 and stays stable until the cycle ack=1 is sampled with valid=1.
interface event_encoder_if;
  logic [7:0] in;
  logic       ack;
  logic [2:0] s;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  modport master (
    output in,
    output ack,
    input  s,
    input  valid,
    input  pending,
    input  overflow
  );

  modport slave (
    input  in,
    input  ack,
    output s,
    output valid,
    output pending,
    output overflow
  );
endinterface

// File: rtl/event_encoder.sv
// Registered 8-to-3 event encoder: latches rising edges into a pending set and
// presents one priority-encoded index at a time until it is acknowledged.
module event_encoder #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  event_encoder_if.slave bus,
  output logic           state_dbg
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [7:0] in_q;
  logic [7:0] pending_q, pending_next;
  logic [7:0] rise, clr;
  logic [2:0] s_q, s_next, enc;
  logic       ovf_q, ovf_next;

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) r = i[2:0];
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) r = i[2:0];
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_q       <= 3'd0;
      in_q      <= 8'h00;
      pending_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_next;
      s_q       <= s_next;
      in_q      <= bus.in;
      pending_q <= pending_next;
      ovf_q     <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s_q;
    clr        = 8'h00;
    rise       = bus.in & ~in_q;
    enc        = encode(pending_q);
    case (state)
      IDLE: begin
        if (|pending_q) begin
          s_next     = enc;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        // The code stays frozen here even if a higher-priority event arrives.
        if (bus.ack) begin
          clr        = 8'b1 << s_q;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A rise on a bit being cleared this cycle is a fresh event, not a loss.
    pending_next = (pending_q & ~clr) | rise;
    ovf_next     = ovf_q | (|(rise & pending_q & ~clr));
  end

  assign bus.s        = s_q;
  assign bus.valid    = (state == PRESENT);
  assign bus.pending  = pending_q;
  assign bus.overflow = ovf_q;
  assign state_dbg    = (state == PRESENT);

endmodule

// File: doc/event_encoder.md
# event_encoder

Registered 8-to-3 event encoder: the inverse of the lab's 3-to-8 select decoder. It captures rising edges on eight event lines into a pending register, presents the highest-priority pending index as a 3-bit code with a valid/ack handshake, and clears each event once the consumer acknowledges it. It sits between synchronized switch/button or status lines and downstream logic that accepts one select code at a time.

## Interface
- PRIORITY_HIGH, default 1: 1 = highest pending index wins; 0 = lowest pending index wins.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- In  input  8  event lines; already synchronized to clk; a rising edge is one event.
- Ack  input  1  consumer accepts the presented code; meaningful only while Valid=1.
- S  output  3  encoded index of the presented event.
- Valid  output  1  S holds a pending event awaiting Ack.
- Pending  output  8  current pending-event register.
- Overflow  output  1  sticky: an event was lost because its bit was already pending.

## Operation
- Edge detect: In_q registers In each cycle; rise = In & ~In_q. In_q resets to 0, so a line already high when reset releases counts as one event on the first clock.
- Pending update each cycle: Pending_next = (Pending & ~clr) | rise, where clr is a one-hot of S when Ack=1 and Valid=1, else 0.
- Rise and clear on the same bit in the same cycle: the bit stays set and Overflow is not set. The new event is kept.
- Overflow is set when a rise hits a bit that is already pending and not being cleared in that cycle. It stays set until reset.
- Priority encode: an 8-to-3 encoder over Pending. With PRIORITY_HIGH=1, bit 7 wins; with 0, bit 0 wins.
- FSM, two states:
  - IDLE: Valid=0. If Pending != 0, register S = encode(Pending) and Valid=1, then go to PRESENT. Otherwise stay.
  - PRESENT: Valid=1 and S is held stable, even if a higher-priority event arrives. On Ack=1: clear Pending[S], drop Valid, go to IDLE. Otherwise stay.
- Ack while in IDLE (Valid=0) is ignored: no clear, no state change.
- Reset (asynchronous, any time, including mid-handshake): state=IDLE, S=3'b000, Valid=0, Pending=8'h00, Overflow=0, In_q=8'h00. Any presented event is discarded.

## Timing
- Event latency: In rises before edge k → Pending bit set after edge k → S/Valid valid after edge k+1 (2 cycles).
- Ack sampled at edge m with Valid=1 → after edge m: Valid=0, Pending bit cleared. The next code can appear after edge m+1.
- Maximum throughput is one event per 2 cycles, with Ack held high continuously.
- S, Valid, Pending and Overflow are all registered. There is no combinational path from In or Ack to any output.
- Ack may be held high permanently. Each presentation is then consumed after exactly one PRESENT cycle.

## Test plan
- Reset: hold rst_n=0 with In=8'hFF, then release → the first edge gives Pending=8'hFF. With PRIORITY_HIGH=1, the next edge gives Valid=1, S=3'd7. Asserting rst_n=0 mid-PRESENT clears all outputs immediately, without waiting for a clock.
- Single event: pulse In[3] for 1 cycle with Ack=0 → after 2 edges Valid=1, S=3. Valid/S stay held for 10 cycles. Ack for 1 cycle → Valid=0, Pending=8'h00.
- Priority and stability: raise In[2], and 1 cycle after Valid asserts raise In[6] → S stays 2 until Ack. The next presentation is S=6. With PRIORITY_HIGH=0 and In[2], In[6] rising together → S=2 first, then S=6.
- Back-to-back: Ack held at 1 with In 8'h00→8'hA5 in one step → codes 7, 5, 2, 0, with Valid asserted on alternate cycles. Then Pending=0 and Overflow=0.
- Overflow: raise In[1], drop it, and raise it again while bit 1 is still pending (Ack=0) → Overflow=1 and stays 1 after Ack.
- Same-cycle collision: time a second rise of In[4] so it is sampled on the same edge as the Ack of S=4 → Pending[4] remains 1, Overflow stays 0, and S=4 is presented again.
